// File: rtl/conv_x_stream_tx.sv
// conv_x_stream_tx: holds one LENX-word frame written by a host and streams it over valid/ready.
// Define CONV_TX_LAST_EN to add the m_last_x end-of-frame marker output.
module conv_x_stream_tx #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned LENX  = 30,
  parameter int unsigned ADDRX = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [ADDRX-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] m_data_out_x,
  output logic             m_valid_x,
`ifdef CONV_TX_LAST_EN
  output logic             m_last_x,
`endif
  input  logic             m_ready_x
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [ADDRX-1:0] LAST_ADDR = ADDRX'(LENX - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q [LENX];
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_last_q, rd_last_d;
  logic [ADDRX-1:0] ptr_q, ptr_d;
  logic             issued_all_q, issued_all_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             skid_last_q, skid_last_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             active, wr_ok, pop, issue;

  assign active = (state_q == FETCH) || (state_q == SEND);
  assign wr_ok  = wr_en && !active && (32'(wr_addr) < LENX);

  always_ff @(posedge clk) begin
    if (wr_ok) buf_q[wr_addr] <= wr_data;
    if (issue) rd_data_q <= buf_q[ptr_q];
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    ptr_d        = ptr_q;
    issued_all_d = issued_all_q;
    pop          = out_valid_q && m_ready_x;

    // Output register refills from skid first, then from the read returning this cycle;
    // a read that cannot enter the output register parks in the skid.
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = rd_vld_q;
        skid_data_d  = rd_data_q;
        skid_last_d  = rd_last_q;
      end else begin
        out_valid_d = rd_vld_q;
        out_data_d  = rd_vld_q ? rd_data_q : '0;
        out_last_d  = rd_vld_q && rd_last_q;
      end
    end else if (rd_vld_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rd_data_q;
      skid_last_d  = rd_last_q;
    end

    // Only launch a read if its data is guaranteed a slot next cycle even with ready low.
    issue     = active && !issued_all_q && !(out_valid_d && skid_valid_d);
    rd_vld_d  = issue;
    rd_last_d = issue && (ptr_q == LAST_ADDR);
    if (issue) begin
      if (ptr_q == LAST_ADDR) issued_all_d = 1'b1;
      else                    ptr_d = ptr_q + 1'b1;
    end

    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = SEND;
      SEND: begin
        if (pop && out_last_q) begin
          state_d      = DONE;
          ptr_d        = '0;
          issued_all_d = 1'b0;
        end
      end
      DONE:    state_d = start ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      ptr_q        <= '0;
      issued_all_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      ptr_q        <= ptr_d;
      issued_all_q <= issued_all_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign busy         = active;
  assign done         = (state_q == DONE);
  assign m_valid_x    = out_valid_q;
  assign m_data_out_x = out_data_q;
`ifdef CONV_TX_LAST_EN
  assign m_last_x     = out_last_q;
`endif

endmodule
